// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_DATA,
      ST_DONE,
      ST_ERR
   } ld_state_e;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// rx_valid pulse carrying the byte and its framing-error flag.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_ferr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   rx_state_e       state_q, state_d;
   logic            rx_meta_q, rx_sync_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = ferr_q;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (!rx_sync_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               bit_d = 3'd0;
               // A line that is high again at mid start bit was only a glitch.
               state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = RX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               valid_d = 1'b1;
               ferr_d  = !rx_sync_q;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx_valid = valid_q;
   assign rx_data  = shift_q;
   assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: takes a length-prefixed little-endian word image from the UART,
// writes it into instruction memory and releases the CPU once it is complete.
module uart_imem_loader
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 14,
   parameter int TIMEOUT      = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  start,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           word_cnt
);

   localparam int HDR_W = 8 * HDR_BYTES;
   localparam int IDX_W = $clog2(BYTES_PER_WORD);
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
   localparam logic [HDR_W:0]   DEPTH    = (HDR_W + 1)'(2 ** ADDR_WIDTH);

   logic       rx_valid, rx_ferr;
   logic [7:0] rx_data;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ferr  (rx_ferr)
   );

   ld_state_e             state_q, state_d;
   logic [HDR_W-1:0]      n_q, n_d, n_full;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [31:0]           word_q, word_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [15:0]           cnt_q, cnt_d, cnt_inc;
   logic                  cpu_rst_q, busy_q, done_q, err_q;

   assign n_full  = {rx_data, n_q[7:0]};
   assign cnt_inc = cnt_q + 16'd1;

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      word_d  = word_q;
      tmo_d   = '0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      if (start) begin
         // Restart wins over a byte arriving in the same cycle; that byte is lost.
         state_d = ST_HDR0;
         n_d     = '0;
         idx_d   = '0;
         word_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_HDR0: begin
               if (rx_valid) begin
                  if (rx_ferr) state_d = ST_ERR;
                  else begin
                     n_d[7:0] = rx_data;
                     state_d  = ST_HDR1;
                  end
               end
            end
            ST_HDR1: begin
               if (rx_valid) begin
                  if (rx_ferr) state_d = ST_ERR;
                  else begin
                     n_d = n_full;
                     if (n_full == '0)               state_d = ST_DONE;
                     else if ({1'b0, n_full} > DEPTH) state_d = ST_ERR;
                     else                             state_d = ST_DATA;
                  end
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  state_d = ST_ERR;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  if (rx_ferr) state_d = ST_ERR;
                  else if (idx_q == LAST_IDX) begin
                     we_d    = 1'b1;
                     addr_d  = cnt_q[ADDR_WIDTH-1:0];
                     wdata_d = {rx_data, word_q[23:0]};
                     cnt_d   = cnt_inc;
                     idx_d   = '0;
                     word_d  = '0;
                     if (cnt_inc == n_q) state_d = ST_DONE;
                  end else begin
                     word_d[8*idx_q +: 8] = rx_data;
                     idx_d                = idx_q + IDX_W'(1);
                  end
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  state_d = ST_ERR;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         n_q       <= '0;
         idx_q     <= '0;
         word_q    <= '0;
         tmo_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         cpu_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         // Status trails the state by a cycle so the CPU leaves reset after the last write.
         if (start) begin
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
         end else begin
            cpu_rst_q <= (state_q != ST_DONE);
            busy_q    <= (state_q inside {ST_HDR0, ST_HDR1, ST_DATA});
            done_q    <= (state_q == ST_DONE);
            err_q     <= (state_q == ST_ERR);
         end
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader with a short bit time and timeout.
module tb_uart_imem_loader;
   import loader_pkg::*;

   localparam int CPB = 16;
   localparam int AW  = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx = 1'b1;
   logic          start = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst, busy, done, err;
   logic [15:0]   word_cnt;

   int total = 0;
   int bad   = 0;

   uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .TIMEOUT(200)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .start      (start),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   // Observation of DUT activity, sampled on the falling edge.
   int            cyc = 0;
   int            nwr = 0;
   int            vcnt = 0;
   int            wr_cyc [0:31];
   logic [31:0]   wr_data [0:31];
   logic [AW-1:0] wr_addr [0:31];
   logic          done_prev = 1'b0;
   int            done_cyc = -1;
   logic [7:0]    last_rxd = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      done_prev <= done;
      if (done && !done_prev) done_cyc <= cyc;
      if (imem_we) begin
         wr_data[nwr & 31] <= imem_wdata;
         wr_addr[nwr & 31] <= imem_addr;
         wr_cyc[nwr & 31]  <= cyc;
         nwr               <= nwr + 1;
      end
      if (dut.rx_valid) begin
         vcnt     <= vcnt + 1;
         last_rxd <= dut.rx_data;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_b);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_b;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      send_byte(b, 1'b1);
      $display("sent byte %h t=%0t", b, $time);
   endtask

   task automatic pulse_start;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int base;
      int vbase;
      logic found;

      repeat (3) @(negedge clk);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_flags", {busy, done, err, imem_we}, 4'b0000);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_word_cnt", word_cnt, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Normal two-word load.
      base = nwr;
      pulse_start();
      @(negedge clk);
      chk("t1_busy", busy, 1);
      chk("t1_cpu_rst_held", cpu_rst, 1);
      send(8'h02); send(8'h00); send(8'h13); send(8'h05); send(8'hA0);
      send(8'h00); send(8'h93); send(8'h05); send(8'hF0); send(8'hFF);
      repeat (4) @(negedge clk);
      chk("t1_nwr", nwr - base, 2);
      chk("t1_addr0", wr_addr[base], 0);
      chk("t1_data0", wr_data[base], 32'h00A00513);
      chk("t1_addr1", wr_addr[base+1], 1);
      chk("t1_data1", wr_data[base+1], 32'hFFF00593);
      chk("t1_word_cnt", word_cnt, 2);
      chk("t1_done", {done, cpu_rst, busy, err}, 4'b1000);
      chk("t1_done_latency", done_cyc, wr_cyc[base+1] + 1);

      // Bytes arriving in DONE are ignored.
      base = nwr;
      send(8'h55);
      repeat (4) @(negedge clk);
      chk("done_ignore_nwr", nwr - base, 0);
      chk("done_ignore_done", done, 1);

      // Empty image.
      base = nwr;
      pulse_start();
      send(8'h00); send(8'h00);
      repeat (4) @(negedge clk);
      chk("t2_nwr", nwr - base, 0);
      chk("t2_done", {done, cpu_rst}, 2'b10);
      chk("t2_word_cnt", word_cnt, 0);

      // Framing error, then recovery.
      base = nwr;
      pulse_start();
      send(8'h01); send(8'h00);
      send_byte(8'h3C, 1'b0);
      $display("sent byte 3c with stop=0 t=%0t", $time);
      repeat (4) @(negedge clk);
      chk("t3_err", {err, cpu_rst, busy, done}, 4'b1100);
      chk("t3_nwr", nwr - base, 0);
      repeat (30 * CPB) @(negedge clk);
      pulse_start();
      send(8'h01); send(8'h00); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      repeat (4) @(negedge clk);
      chk("t3_recover_data", wr_data[base], 32'h12345678);
      chk("t3_recover_flags", {err, done, cpu_rst}, 3'b010);
      chk("t3_recover_cnt", word_cnt, 1);

      // Inter-byte timeout.
      base = nwr;
      pulse_start();
      send(8'h01); send(8'h00); send(8'hAA);
      repeat (150) @(negedge clk);
      chk("t4_before_timeout", err, 0);
      repeat (100) @(negedge clk);
      chk("t4_timeout_err", {err, busy, cpu_rst}, 3'b101);
      chk("t4_nwr", nwr - base, 0);

      // Oversize image length, then exactly full depth.
      pulse_start();
      send(8'h01); send(8'h40);
      repeat (3) @(negedge clk);
      chk("t4_oversize_err", err, 1);
      pulse_start();
      send(8'h00); send(8'h40);
      repeat (3) @(negedge clk);
      chk("t4_full_depth_state", 32'(dut.state_q), 32'(ST_DATA));
      chk("t4_full_depth_flags", {err, busy}, 2'b01);

      // Restart in the same cycle as a received byte.
      base = nwr;
      pulse_start();
      send(8'h02); send(8'h00); send(8'h11); send(8'h22);
      found = 1'b0;
      fork
         send(8'h33);
         begin
            for (int i = 0; i < 20 * CPB; i++) begin
               @(negedge clk);
               if (dut.rx_valid) begin
                  found = 1'b1;
                  break;
               end
            end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      chk("t5_align_found", found, 1);
      chk("t5_state_hdr0", 32'(dut.state_q), 32'(ST_HDR0));
      chk("t5_word_cnt", word_cnt, 0);
      send(8'h01); send(8'h00); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      repeat (4) @(negedge clk);
      chk("t5_nwr", nwr - base, 1);
      chk("t5_data", wr_data[base], 32'hEFBEADDE);
      chk("t5_done", done, 1);

      // Reset in the middle of a load.
      base = nwr;
      pulse_start();
      send(8'h02); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h55);
      chk("t5_pre_rst_cnt", word_cnt, 1);
      chk("t5_pre_rst_wdata", imem_wdata, 32'h44332211);
      fork
         send(8'h66);
         begin
            repeat (40) @(negedge clk);
            rst = 1'b1;
            #1;
            chk("t5_rst_cpu_rst", cpu_rst, 1);
            chk("t5_rst_flags", {busy, done, err, imem_we}, 4'b0000);
            chk("t5_rst_wdata", imem_wdata, 0);
            chk("t5_rst_cnt", word_cnt, 0);
         end
      join
      repeat (5) @(negedge clk);
      rst = 1'b0;
      send(8'h77); send(8'h88);
      repeat (4) @(negedge clk);
      chk("t5_rst_nwr", nwr - base, 1);
      chk("t5_rst_idle_cpu", {cpu_rst, busy}, 2'b10);

      // False start glitch, then a byte received while idle.
      vbase = vcnt;
      base  = nwr;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("t6_glitch_no_valid", vcnt - vbase, 0);
      send(8'hA5);
      repeat (4) @(negedge clk);
      chk("t6_idle_valid", vcnt - vbase, 1);
      chk("t6_idle_rxdata", last_rxd, 8'hA5);
      chk("t6_idle_nwr", nwr - base, 0);
      chk("t6_idle_flags", {cpu_rst, busy, done}, 3'b100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Upstream boot stage for the single-cycle RISC-V CPU.
- Receives a program image over a UART line, assembles 32-bit little-endian words and writes them sequentially into the instruction memory read by IFetch.
- Holds the CPU in reset until a complete, error-free image has been written.
- Contains a UART 8N1 receiver front end and a loader state machine.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud)
- ADDR_WIDTH, 14, instruction memory word-address width; depth = 2^ADDR_WIDTH words
- TIMEOUT, 1000000, maximum idle cycles between bytes during a load before aborting

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx  input  1  UART line; idles high; asynchronous to clk
- start  input  1  one-cycle pulse; begins a load, or restarts one
- imem_we  output  1  instruction memory write strobe; one-cycle pulse
- imem_addr  output  ADDR_WIDTH  word address for the write
- imem_wdata  output  32  word to write
- cpu_rst  output  1  active-high reset to the CPU core
- busy  output  1  load in progress
- done  output  1  image loaded; CPU released
- err  output  1  sticky error flag
- word_cnt  output  16  number of words written in the current load

Behaviour:
- Reset: one clock `clk`; `rst` is asynchronous and active-high.
  - While `rst` is asserted: state=IDLE, `cpu_rst`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `done`=0, `err`=0, `word_cnt`=0.
  - Receiver state returns to idle.
  - `rst` asserted in the middle of a load aborts the load; no further writes occur.
- `rx` synchronisation: two-flop synchroniser, reset to 1.
- Receiver, 8N1:
  - A falling edge starts the frame.
  - The start bit is sampled at CLKS_PER_BIT/2. If it is sampled high, the frame is a false start: discard it and return to idle.
  - Data bits are sampled every CLKS_PER_BIT, LSB first.
  - The stop bit is sampled, then the receiver emits a one-cycle `rx_valid` with `rx_data[7:0]` and `rx_ferr` (stop bit = 0).
- Loader FSM states: IDLE, HDR0, HDR1, DATA, DONE, ERR.
  - IDLE: `cpu_rst`=1. Received bytes are ignored.
  - `start` in any state → HDR0. On that transition: clear `err`, `done`, `word_cnt`, the byte index and the word address; `busy`=1, `cpu_rst`=1.
  - `start` has priority over an `rx_valid` in the same cycle; that byte is dropped.
  - HDR0: byte → N[7:0]; go to HDR1.
  - HDR1: byte → N[15:8].
    - N=0 → DONE.
    - N > 2^ADDR_WIDTH → ERR.
    - Otherwise → DATA.
  - DATA: bytes fill the word little-endian: byte 0 → [7:0], byte 1 → [15:8], byte 2 → [23:16], byte 3 → [31:24].
    - On the 4th byte, in the next cycle: `imem_we`=1, `imem_addr`=k, `imem_wdata`=word.
    - Then k increments, `word_cnt` increments, and the byte index wraps to 0.
    - When `word_cnt` reaches N → DONE, in the same cycle as the final `imem_we`.
  - DONE: `cpu_rst`=0, `done`=1, `busy`=0. Bytes are ignored.
  - ERR: `err`=1, `cpu_rst`=1, `busy`=0. Bytes are ignored. Exit only through `start` or `rst`.
- Errors: any `rx_ferr` in HDR0, HDR1 or DATA → ERR. The byte is discarded and not written.
- Timeout:
  - Counter runs in HDR1 and DATA; it is cleared on every `rx_valid` and on entry to each state.
  - Reaching TIMEOUT → ERR.
  - HDR0 has no timeout; it waits indefinitely for the first byte.
- Address wrap: impossible by construction, since N ≤ depth is checked in HDR1.
- `imem_we` is never asserted outside DATA→write cycles. Outputs are registered.
- Latency:
  - Stop-bit sample to `rx_valid`: 1 cycle.
  - `rx_valid` of the 4th byte to `imem_we`: 1 cycle.
  - Final write to `cpu_rst` deassert: 1 cycle.

Decomposition:
- Shared package (`loader_pkg`):
  - loader state enum (IDLE, HDR0, HDR1, DATA, DONE, ERR)
  - constant for the header byte count (2)
  - constant for bytes per word (4)
- Sub-module `uart_rx`: the synchroniser, the bit-timing counter and the receiver FSM (IDLE, START, DATA, STOP).
  - Ports: `clk`, `rst`, `rx`, `rx_valid`, `rx_data`, `rx_ferr`.
  - `uart_imem_loader` instantiates it once.

Test Plan:
- Normal load, CLKS_PER_BIT=16: `rst`, `start`, bytes 02 00 13 05 A0 00 93 05 F0 FF → `imem_we`@0=0x00A00513 and `imem_we`@1=0xFFF00593; `word_cnt`=2; `done`=1, `cpu_rst`=0 one cycle after the 2nd write.
- Empty image: `start`, bytes 00 00 → DONE with no `imem_we` pulses; `cpu_rst`=0; `word_cnt`=0.
- Framing error: `start`, 01 00, then a byte with stop bit 0 → `err`=1, `cpu_rst`=1, no write. A later `start` plus a valid image → `err`=0, DONE.
- Timeout, TIMEOUT=200: `start`, 01 00 AA, then line idle 200 cycles → ERR, `imem_we` never asserted. Also cover oversize N = 2^ADDR_WIDTH+1 → ERR after HDR1.
- Restart and reset mid-load: `start`, 02 00 11 22, then `start` pulsed in the same cycle as `rx_valid` → byte dropped, state HDR0, `word_cnt`=0. Assert `rst` mid-DATA → all outputs at reset values immediately, `cpu_rst`=1.
- False start and ignored bytes: 4-cycle low glitch on `rx` → no `rx_valid`. Bytes sent while in IDLE or DONE → no writes; `done` unchanged.
